// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered MIPS branch resolution with bimodal BHT
// Resolves the eight conditional branches one cycle after accept and trains the BHT on output fire.
module branch_resolve_unit #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    op,
  input  logic [4:0]    rt,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [AW-1:0] pc,
  input  logic [15:0]   imm16,
  input  logic          pred_taken,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          is_branch,
  output logic          taken,
  output logic [AW-1:0] target,
  output logic          link_en,
  output logic [AW-1:0] link_addr,
  output logic          mispredict,
  output logic [AW-1:0] redirect_pc,
  input  logic [AW-1:0] q_pc,
  output logic          q_taken
);

  localparam int IDX = $clog2(BHT_DEPTH);

  logic          br, cond, lnk;
  logic          a_neg, a_zero;
  logic [AW-1:0] offset, pc4, pc8, tgt, redir;
  logic          accept, fire;
  logic [IDX-1:0] held_idx;
  logic [1:0]    bht [BHT_DEPTH];
  logic          unused_q_bits;

  assign a_neg  = a[DW-1];
  assign a_zero = (a == '0);

  always_comb begin
    br   = 1'b0;
    cond = 1'b0;
    lnk  = 1'b0;
    case (op)
      6'b000100: begin br = 1'b1; cond = (a == b); end
      6'b000101: begin br = 1'b1; cond = (a != b); end
      6'b000111: begin br = 1'b1; cond = !a_neg && !a_zero; end
      6'b000110: begin br = 1'b1; cond = a_neg || a_zero; end
      6'b000001: begin
        case (rt)
          5'b00001, 5'b10001: begin br = 1'b1; cond = !a_neg; lnk = rt[4]; end
          5'b00000, 5'b10000: begin br = 1'b1; cond = a_neg;  lnk = rt[4]; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Sign-extend to full address width before scaling so negative offsets wrap correctly.
  assign offset = {{(AW-16){imm16[15]}}, imm16} << 2;
  assign pc4    = pc + AW'(4);
  assign pc8    = pc + AW'(8);
  assign tgt    = pc4 + offset;
  assign redir  = cond ? tgt : (br ? pc8 : pc4);

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign fire     = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      is_branch   <= 1'b0;
      taken       <= 1'b0;
      target      <= '0;
      link_en     <= 1'b0;
      link_addr   <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      held_idx    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      is_branch   <= br;
      taken       <= cond;
      target      <= tgt;
      link_en     <= lnk;
      link_addr   <= pc8;
      mispredict  <= cond != pred_taken;
      redirect_pc <= redir;
      held_idx    <= pc[IDX+1:2];
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (fire && is_branch) begin
      if (taken && bht[held_idx] != 2'b11)
        bht[held_idx] <= bht[held_idx] + 2'b01;
      else if (!taken && bht[held_idx] != 2'b00)
        bht[held_idx] <= bht[held_idx] - 2'b01;
    end
  end

  // Read sees the pre-update counter; there is deliberately no write bypass.
  assign q_taken       = bht[q_pc[IDX+1:2]][1];
  assign unused_q_bits = ^{q_pc[AW-1:IDX+2], q_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [5:0]  op;
  logic [4:0]  rt;
  logic [31:0] a, b, pc, q_pc;
  logic [15:0] imm16;
  logic        pred_taken, out_valid, out_ready;
  logic        is_branch, taken, link_en, mispredict, q_taken;
  logic [31:0] target, link_addr, redirect_pc;

  int checks = 0;
  int failures = 0;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rt(rt), .a(a), .b(b), .pc(pc), .imm16(imm16), .pred_taken(pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .is_branch(is_branch), .taken(taken),
    .target(target), .link_en(link_en), .link_addr(link_addr), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .q_pc(q_pc), .q_taken(q_taken)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [5:0] o, input logic [4:0] r, input logic [31:0] va,
                     input logic [31:0] vb, input logic [31:0] p, input logic [15:0] im,
                     input logic pr);
    in_valid = 1'b1; op = o; rt = r; a = va; b = vb; pc = p; imm16 = im; pred_taken = pr;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; q_pc = 32'h40;
    op = '0; rt = '0; a = '0; b = '0; pc = '0; imm16 = '0; pred_taken = 1'b0;
    tick; tick;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_taken", {31'b0, taken}, 32'd0);
    chk("reset_target", target, 32'd0);
    chk("reset_q_taken", {31'b0, q_taken}, 32'd0);
    rst = 1'b0;

    // BEQ taken, predicted not-taken
    req(6'b000100, 5'd0, 32'd5, 32'd5, 32'h100, 16'h0003, 1'b0);
    chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
    tick;
    chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_is_branch", {31'b0, is_branch}, 32'd1);
    chk("t1_taken", {31'b0, taken}, 32'd1);
    chk("t1_target", target, 32'h110);
    chk("t1_mispredict", {31'b0, mispredict}, 32'd1);
    chk("t1_redirect", redirect_pc, 32'h110);
    chk("t1_link_en", {31'b0, link_en}, 32'd0);

    // BGEZAL a=0 taken; BLTZAL a=0 not taken, still links
    req(6'b000001, 5'b10001, 32'd0, 32'd0, 32'h200, 16'h0000, 1'b1);
    tick;
    chk("t2_bgezal_taken", {31'b0, taken}, 32'd1);
    chk("t2_bgezal_link_en", {31'b0, link_en}, 32'd1);
    chk("t2_bgezal_link_addr", link_addr, 32'h208);
    chk("t2_bgezal_mispredict", {31'b0, mispredict}, 32'd0);
    req(6'b000001, 5'b10000, 32'd0, 32'd0, 32'h200, 16'h0000, 1'b0);
    tick;
    chk("t2_bltzal_taken", {31'b0, taken}, 32'd0);
    chk("t2_bltzal_link_en", {31'b0, link_en}, 32'd1);
    chk("t2_bltzal_redirect", redirect_pc, 32'h208);

    // BGTZ zero, BLEZ negative, wrapping target
    req(6'b000111, 5'd0, 32'd0, 32'd0, 32'h100, 16'h0001, 1'b0);
    tick;
    chk("t3_bgtz_taken", {31'b0, taken}, 32'd0);
    chk("t3_bgtz_is_branch", {31'b0, is_branch}, 32'd1);
    req(6'b000110, 5'd0, 32'h8000_0000, 32'd0, 32'h100, 16'h0001, 1'b1);
    tick;
    chk("t3_blez_taken", {31'b0, taken}, 32'd1);
    chk("t3_blez_target", target, 32'h108);
    req(6'b000100, 5'd0, 32'd7, 32'd7, 32'h0, 16'hFFFF, 1'b1);
    tick;
    chk("t3_wrap_target", target, 32'h0);
    chk("t3_wrap_taken", {31'b0, taken}, 32'd1);

    // Backpressure: hold two cycles, then back-to-back
    out_ready = 1'b0;
    req(6'b000101, 5'd0, 32'd1, 32'd2, 32'h300, 16'h0001, 1'b1);
    #1;
    chk("t4_in_ready_low", {31'b0, in_ready}, 32'd0);
    tick;
    chk("t4_hold1_valid", {31'b0, out_valid}, 32'd1);
    chk("t4_hold1_target", target, 32'h0);
    tick;
    chk("t4_hold2_target", target, 32'h0);
    chk("t4_hold2_in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("t4_in_ready_high", {31'b0, in_ready}, 32'd1);
    tick;
    chk("t4_b2b1_target", target, 32'h308);
    chk("t4_b2b1_taken", {31'b0, taken}, 32'd1);
    chk("t4_b2b1_mispredict", {31'b0, mispredict}, 32'd0);
    req(6'b000100, 5'd0, 32'd1, 32'd2, 32'h400, 16'h0002, 1'b0);
    tick;
    chk("t4_b2b2_valid", {31'b0, out_valid}, 32'd1);
    chk("t4_b2b2_taken", {31'b0, taken}, 32'd0);
    chk("t4_b2b2_redirect", redirect_pc, 32'h408);
    in_valid = 1'b0;
    tick;
    chk("t4_drained", {31'b0, out_valid}, 32'd0);

    // BHT training at pc 0x40, saturation, flush suppression, decrement
    q_pc = 32'h40;
    req(6'b000101, 5'd0, 32'd1, 32'd2, 32'h40, 16'h0000, 1'b0);
    tick;
    chk("t5_before_fire", {31'b0, q_taken}, 32'd0);
    tick;
    chk("t5_ctr10", {31'b0, q_taken}, 32'd1);
    tick;
    chk("t5_ctr11", {31'b0, q_taken}, 32'd1);
    req(6'b000101, 5'd0, 32'd1, 32'd1, 32'h40, 16'h0000, 1'b0);
    tick;
    chk("t5_ctr11_sat", {31'b0, q_taken}, 32'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("t5_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_flush_q_taken", {31'b0, q_taken}, 32'd1);
    tick;
    in_valid = 1'b0;
    tick;
    chk("t5_dec_ctr10", {31'b0, q_taken}, 32'd1);
    req(6'b000101, 5'd0, 32'd1, 32'd1, 32'h40, 16'h0000, 1'b0);
    tick;
    in_valid = 1'b0;
    tick;
    chk("t5_dec_ctr01", {31'b0, q_taken}, 32'd0);

    // Non-branch op
    q_pc = 32'h80;
    req(6'b100011, 5'd0, 32'd0, 32'd0, 32'h80, 16'h0000, 1'b1);
    tick;
    in_valid = 1'b0;
    chk("t6_nb_is_branch", {31'b0, is_branch}, 32'd0);
    chk("t6_nb_taken", {31'b0, taken}, 32'd0);
    chk("t6_nb_link_en", {31'b0, link_en}, 32'd0);
    chk("t6_nb_mispredict", {31'b0, mispredict}, 32'd1);
    chk("t6_nb_redirect", redirect_pc, 32'h84);
    tick;
    chk("t6_nb_no_train", {31'b0, q_taken}, 32'd0);

    // Train 0x40 up, then reset while a result is held
    q_pc = 32'h40;
    req(6'b000101, 5'd0, 32'd3, 32'd4, 32'h40, 16'h0000, 1'b1);
    tick; tick; tick;
    chk("t6_retrained", {31'b0, q_taken}, 32'd1);
    out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    chk("t6_held_valid", {31'b0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_bht", {31'b0, q_taken}, 32'd0);
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("t6_post_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_post_rst_bht", {31'b0, q_taken}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
